// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the 16-bit single-port CPU memory interface.
//   Serves CPU reads/writes from an internal word array, and provides a
//   byte-stream load port that fills the array with a big-endian image
//   while the CPU is held in reset.
//
// Ports
//   clock, reset                     : single clock, synchronous active-high reset
//   MEMCTRL_MEM_to_mem_mem_enable    : CPU request qualifier
//   MEMCTRL_MEM_to_mem_read_enable   : CPU read request
//   MEMCTRL_MEM_to_mem_write_enable  : CPU write request
//   MEMCTRL_MEM_to_mem_address       : CPU word address
//   MEMCTRL_MEM_to_mem_data          : CPU write data
//   MEM_MEMCTRL_from_mem_data        : registered read data (1-cycle latency)
//   load_active                      : load mode, load port owns the array
//   load_valid / load_byte           : image byte stream (file order)
//   load_ready                       : byte accepted on load_valid & load_ready
//   load_word_count                  : words written since load start (saturating)
//   load_overflow                    : sticky, image wrapped past the last word
module mem_responder #(
  parameter int MEM_DEPTH  = 4096,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  MEMCTRL_MEM_to_mem_mem_enable,
  input  logic                  MEMCTRL_MEM_to_mem_read_enable,
  input  logic                  MEMCTRL_MEM_to_mem_write_enable,
  input  logic [ADDR_WIDTH-1:0] MEMCTRL_MEM_to_mem_address,
  input  logic [15:0]           MEMCTRL_MEM_to_mem_data,
  output logic [15:0]           MEM_MEMCTRL_from_mem_data,
  input  logic                  load_active,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  output logic                  load_ready,
  output logic [ADDR_WIDTH:0]   load_word_count,
  output logic                  load_overflow
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_HI   = 2'd1,
    LD_LO   = 2'd2
  } load_state_t;

  load_state_t           state_r;
  load_state_t           state_next_s;
  logic                  load_ready_s;
  logic                  load_start_s;
  logic                  hi_take_s;
  logic                  lo_take_s;
  logic                  cpu_req_s;
  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_waddr_s;
  logic [15:0]           mem_wdata_s;

  logic [15:0]           mem_r [0:MEM_DEPTH-1];
  logic [15:0]           dout_r;
  logic [ADDR_WIDTH-1:0] load_addr_r;
  logic [CW-1:0]         load_count_r;
  logic                  load_overflow_r;
  logic [7:0]            hi_byte_r;

  // CPU requests are only honoured while the load port is not in control.
  assign cpu_req_s = ~load_active & MEMCTRL_MEM_to_mem_mem_enable;

  // Load FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= LD_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Load FSM next-state and byte-acceptance decode
  always_comb begin
    state_next_s = state_r;
    load_ready_s = 1'b0;
    load_start_s = 1'b0;
    hi_take_s    = 1'b0;
    lo_take_s    = 1'b0;
    case (state_r)
      LD_IDLE: begin
        // Level-sensitive start: this also restarts a load when load_active
        // is still high after a reset.
        if (load_active) begin
          state_next_s = LD_HI;
          load_start_s = 1'b1;
        end else begin
          state_next_s = LD_IDLE;
        end
      end
      LD_HI: begin
        if (!load_active) begin
          state_next_s = LD_IDLE;
        end else begin
          load_ready_s = 1'b1;
          if (load_valid) begin
            hi_take_s    = 1'b1;
            state_next_s = LD_LO;
          end else begin
            state_next_s = LD_HI;
          end
        end
      end
      LD_LO: begin
        // Dropping load_active here discards the pending high byte.
        if (!load_active) begin
          state_next_s = LD_IDLE;
        end else begin
          load_ready_s = 1'b1;
          if (load_valid) begin
            lo_take_s    = 1'b1;
            state_next_s = LD_HI;
          end else begin
            state_next_s = LD_LO;
          end
        end
      end
      default: begin
        state_next_s = LD_IDLE;
      end
    endcase
  end

  // Array write-port arbitration between load stream and CPU
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = MEMCTRL_MEM_to_mem_address;
    mem_wdata_s = MEMCTRL_MEM_to_mem_data;
    if (reset) begin
      mem_we_s = 1'b0;
    end else if (lo_take_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = load_addr_r;
      mem_wdata_s = {hi_byte_r, load_byte};
    end else if (cpu_req_s && MEMCTRL_MEM_to_mem_write_enable) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Word array storage (contents survive reset)
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // CPU read data register; read+write forwards the write data
  always_ff @(posedge clock) begin
    if (reset) begin
      dout_r <= 16'h0000;
    end else if (cpu_req_s && MEMCTRL_MEM_to_mem_read_enable && MEMCTRL_MEM_to_mem_write_enable) begin
      dout_r <= MEMCTRL_MEM_to_mem_data;
    end else if (cpu_req_s && MEMCTRL_MEM_to_mem_read_enable) begin
      dout_r <= mem_r[MEMCTRL_MEM_to_mem_address];
    end
  end

  // Load address, word counter, overflow flag and pending high byte
  always_ff @(posedge clock) begin
    if (reset) begin
      load_addr_r     <= {ADDR_WIDTH{1'b0}};
      load_count_r    <= {CW{1'b0}};
      load_overflow_r <= 1'b0;
      hi_byte_r       <= 8'h00;
    end else begin
      if (load_start_s) begin
        load_addr_r     <= {ADDR_WIDTH{1'b0}};
        load_count_r    <= {CW{1'b0}};
        load_overflow_r <= 1'b0;
      end else if (lo_take_s) begin
        // Wrap explicitly so non-power-of-two depths also restart at 0.
        if (load_addr_r == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
          load_addr_r     <= {ADDR_WIDTH{1'b0}};
          load_overflow_r <= 1'b1;
        end else begin
          load_addr_r <= load_addr_r + ADDR_WIDTH'(1);
        end
        if (load_count_r != {CW{1'b1}}) begin
          load_count_r <= load_count_r + CW'(1);
        end
      end
      if (hi_take_s) begin
        hi_byte_r <= load_byte;
      end
    end
  end

  assign MEM_MEMCTRL_from_mem_data = dout_r;
  assign load_ready                = load_ready_s;
  assign load_word_count           = load_count_r;
  assign load_overflow             = load_overflow_r;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a word-array
// reference model of the CPU port and the big-endian load stream.
module tb_mem_responder;

  localparam int DEPTH = 4096;
  localparam int AW    = 12;
  localparam int SAT   = 8191;

  typedef logic [7:0] byte_q_t[$];

  logic          clock = 1'b0;
  logic          reset;
  logic          mem_enable, read_enable, write_enable;
  logic [AW-1:0] address;
  logic [15:0]   wdata;
  logic [15:0]   rdata;
  logic          load_active, load_valid, load_ready, load_overflow;
  logic [7:0]    load_byte;
  logic [AW:0]   load_word_count;

  logic [15:0]   mem_m [0:DEPTH-1];
  bit            known_m [0:DEPTH-1];
  logic [15:0]   exp_dout;
  int            n_checks = 0;
  int            n_fail   = 0;

  mem_responder #(.MEM_DEPTH(DEPTH)) dut (
    .clock                           (clock),
    .reset                           (reset),
    .MEMCTRL_MEM_to_mem_mem_enable   (mem_enable),
    .MEMCTRL_MEM_to_mem_read_enable  (read_enable),
    .MEMCTRL_MEM_to_mem_write_enable (write_enable),
    .MEMCTRL_MEM_to_mem_address      (address),
    .MEMCTRL_MEM_to_mem_data         (wdata),
    .MEM_MEMCTRL_from_mem_data       (rdata),
    .load_active                     (load_active),
    .load_valid                      (load_valid),
    .load_byte                       (load_byte),
    .load_ready                      (load_ready),
    .load_word_count                 (load_word_count),
    .load_overflow                   (load_overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_idle();
    mem_enable   = 1'b0;
    read_enable  = 1'b0;
    write_enable = 1'b0;
  endtask

  // One CPU cycle; the model decides what the registered read data must be.
  task automatic cpu_cycle(input bit en, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [15:0] d, input string tag);
    bit exp_valid;
    mem_enable = en; read_enable = rd; write_enable = wr; address = a; wdata = d;
    tick();
    exp_valid = 1'b1;
    if (en && rd && wr) exp_dout = d;
    else if (en && rd) begin
      exp_valid = known_m[a];
      exp_dout  = mem_m[a];
    end
    if (en && wr) begin
      mem_m[a]   = d;
      known_m[a] = 1'b1;
    end
    if (exp_valid) check(tag, 32'(rdata), 32'(exp_dout));
    cpu_idle();
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, input string tag);
    cpu_cycle(1'b1, 1'b1, 1'b0, a, 16'h0000, tag);
  endtask

  // Streams q with random gaps; words/overflow/count follow from byte pairs.
  task automatic do_load(input byte_q_t q, input bit drop, input int gap_pct);
    int words;
    load_active = 1'b1;
    load_valid  = 1'b0;
    tick();
    words = 0;
    for (int i = 0; i < q.size(); i++) begin
      while ($urandom_range(99) < gap_pct) begin
        load_valid = 1'b0;
        tick();
      end
      load_valid = 1'b1;
      load_byte  = q[i];
      check("load_ready", 32'(load_ready), 32'd1);
      tick();
      if (i % 2 == 1) begin
        mem_m[words % DEPTH]   = {q[i-1], q[i]};
        known_m[words % DEPTH] = 1'b1;
        words++;
        check("load_count_run", 32'(load_word_count), 32'((words > SAT) ? SAT : words));
        check("load_ovf_run", 32'(load_overflow), 32'(words >= DEPTH));
      end
    end
    load_valid = 1'b0;
    if (drop) begin
      load_active = 1'b0;
      #1;
      check("load_ready_drop", 32'(load_ready), 32'd0);
      tick();
    end
  endtask

  initial begin
    byte_q_t q;
    reset = 1'b1;
    load_active = 1'b0; load_valid = 1'b0; load_byte = 8'h00;
    address = '0; wdata = 16'h0000;
    cpu_idle();
    for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;
    exp_dout = 16'h0000;
    tick();
    tick();
    check("rst_dout", 32'(rdata), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd0);
    check("rst_count", 32'(load_word_count), 32'd0);
    check("rst_ovf", 32'(load_overflow), 32'd0);
    reset = 1'b0;
    tick();

    // Basic 4-byte load.
    q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    do_load(q, 1'b1, 30);
    check("load4_count", 32'(load_word_count), 32'd2);
    check("load4_ovf", 32'(load_overflow), 32'd0);
    cpu_read(12'h000, "load4_ram0");
    check("load4_ram0_const", 32'(rdata), 32'h1234);
    cpu_read(12'h001, "load4_ram1");
    check("load4_ram1_const", 32'(rdata), 32'hABCD);

    // Write then read back, then hold with mem_enable low.
    cpu_cycle(1'b1, 1'b0, 1'b1, 12'h005, 16'hBEEF, "wr5_hold");
    cpu_read(12'h005, "rd5");
    check("rd5_const", 32'(rdata), 32'hBEEF);
    for (int i = 0; i < 3; i++) cpu_cycle(1'b0, 1'b1, 1'b1, 12'h000, 16'h5555, "hold_en0");

    // Write-through.
    cpu_cycle(1'b1, 1'b1, 1'b1, 12'h010, 16'h1234, "rw10");
    cpu_read(12'h010, "rd10");

    // Random CPU traffic over a small, pre-initialised window.
    for (int a = 0; a < 64; a++) cpu_cycle(1'b1, 1'b0, 1'b1, AW'(a), 16'($urandom), "init_wr");
    for (int i = 0; i < 300; i++)
      cpu_cycle(1'($urandom_range(3) != 0), 1'($urandom), 1'($urandom),
                AW'($urandom_range(63)), 16'($urandom), "rand_cpu");

    // Overflowing load: 4097 words.
    q = {};
    for (int i = 0; i < 2 * (DEPTH + 1); i++) q.push_back(8'($urandom));
    do_load(q, 1'b1, 10);
    check("big_count", 32'(load_word_count), 32'd4097);
    check("big_ovf", 32'(load_overflow), 32'd1);
    cpu_read(12'h000, "big_ram0");
    check("big_ram0_word4097", 32'(rdata), 32'({q[8192], q[8193]}));
    cpu_read(12'h001, "big_ram1");
    cpu_read(12'hFFF, "big_ramlast");

    // Odd trailing byte is dropped.
    q = '{8'h11, 8'h22, 8'h33};
    do_load(q, 1'b1, 20);
    check("odd_count", 32'(load_word_count), 32'd1);
    check("odd_ovf", 32'(load_overflow), 32'd0);
    cpu_read(12'h000, "odd_ram0");
    check("odd_ram0_const", 32'(rdata), 32'h1122);
    cpu_read(12'h001, "odd_ram1_kept");
    q = '{8'h9C, 8'h3E};
    do_load(q, 1'b1, 0);
    cpu_read(12'h000, "next_load_at0");

    // Reset mid-load; CPU write during load is ignored.
    cpu_read(12'h002, "pre_rst_read");
    q = '{8'hA1, 8'hA2, 8'hB1, 8'hB2};
    do_load(q, 1'b0, 20);
    mem_enable = 1'b1; read_enable = 1'b1; write_enable = 1'b1;
    address = 12'h001; wdata = 16'hDEAD;
    tick();
    check("cpu_blocked_dout", 32'(rdata), 32'(exp_dout));
    cpu_idle();
    load_valid = 1'b0;
    tick();
    load_valid = 1'b1; load_byte = 8'h77;
    tick();
    load_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    exp_dout = 16'h0000;
    check("midrst_dout", 32'(rdata), 32'd0);
    check("midrst_ready", 32'(load_ready), 32'd0);
    check("midrst_count", 32'(load_word_count), 32'd0);
    check("midrst_ovf", 32'(load_overflow), 32'd0);
    reset = 1'b0;
    q = '{8'h5A, 8'hA5};
    do_load(q, 1'b1, 20);
    check("restart_count", 32'(load_word_count), 32'd1);
    cpu_read(12'h000, "restart_ram0");
    cpu_read(12'h001, "kept_ram1");
    check("kept_ram1_const", 32'(rdata), 32'hB1B2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
